qsram_access_controller: RTL and testbench
==========================================

Name: qsram_access_controller

Overview:
- Sequences an array of QSRAM cells organised as 2**ADDR_WIDTH rows by DATA_WIDTH bits.
- Each row shares one ReadEdge, one WriteEdge and one RefreshEdge strobe, driven by one-hot row vectors from this block.
- Arbitrates host read/write requests against a periodic refresh that walks every row.
- Guarantees that at most one strobe is active in the whole array in any cycle.

Parameters:
- ADDR_WIDTH, 4: row address width; ROWS = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: bits per row.
- REFRESH_INTERVAL, 64: clock cycles between refresh requests; must be at least 2*(STROBE_CYCLES+1).
- STROBE_CYCLES, 2: cycles each Read/Write/Refresh strobe is held high; must be at least 1.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  host request valid.
- ReqReady  out  1  controller accepts a request this cycle.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_WIDTH  target row.
- ReqWData  in  DATA_WIDTH  write data.
- RspValid  out  1  one-cycle pulse: RspRData is valid.
- RspRData  out  DATA_WIDTH  read data.
- RowReadEdge  out  ROWS  one-hot read strobes.
- RowWriteEdge  out  ROWS  one-hot write strobes.
- RowRefreshEdge  out  ROWS  one-hot refresh strobes.
- ArrayWData  out  DATA_WIDTH  data bus to the cell inputs.
- ArrayRData  in  DATA_WIDTH  data bus from the cell outputs.
- RefreshOverrun  out  1  sticky error flag.

Behaviour:
- Clock and reset: single clock domain, Clock. Reset is synchronous and active-high. While Reset is high:
  - all strobe vectors, RspValid, ReqReady and RefreshOverrun are 0;
  - RspRData and ArrayWData are 0;
  - FSM is IDLE; refresh timer is 0; refresh row pointer is 0; RefreshPending is 0.
  - Reset mid-operation aborts the operation immediately: strobes drop in the cycle after Reset is sampled, and no RspValid is produced.
- FSM states: IDLE, READ, WRITE, REFRESH. Every operation returns to IDLE for at least one cycle, so strobes of consecutive operations never overlap or abut.
- ReqReady = (state == IDLE) && !RefreshPending && !Reset. A request is accepted when ReqValid && ReqReady.
- IDLE priority order: RefreshPending first, then an accepted request, otherwise stay in IDLE.
- READ:
  - On accept in cycle t, the row address is registered.
  - RowReadEdge[addr] = 1 for cycles t+1 through t+STROBE_CYCLES.
  - ArrayRData is sampled on the last strobe cycle.
  - RspValid = 1 in cycle t+STROBE_CYCLES+1, with RspRData holding the sampled value. RspRData holds that value until the next read.
  - FSM returns to IDLE in cycle t+STROBE_CYCLES+1.
- WRITE:
  - On accept in cycle t, ArrayWData is registered from ReqWData and stays stable until the next accepted write.
  - RowWriteEdge[addr] = 1 for cycles t+1 through t+STROBE_CYCLES.
  - No response is produced.
- REFRESH:
  - Entered from IDLE when RefreshPending = 1; entering clears RefreshPending.
  - RowRefreshEdge[ptr] = 1 for STROBE_CYCLES cycles.
  - On exit, ptr increments and wraps from ROWS-1 to 0.
- Refresh timer:
  - Free-running; counts 0 to REFRESH_INTERVAL-1, then wraps to 0.
  - On wrap it sets RefreshPending.
  - If it wraps while RefreshPending is already 1, RefreshOverrun is set to 1 and stays 1 until Reset.
- Simultaneous events:
  - Timer wrap in the same cycle that REFRESH is entered: the new pending request wins, so RefreshPending ends the cycle at 1.
  - A request arriving with RefreshPending = 1 is stalled (ReqReady = 0); the refresh runs first.
- Invariants:
  - $onehot0 over {RowReadEdge, RowWriteEdge, RowRefreshEdge} in every cycle.
  - Strobes are registered outputs, so no combinational path from any input reaches a strobe.
- Out-of-range addresses cannot occur because ROWS = 2**ADDR_WIDTH.

Decomposition:
- Package qsram_ctrl_pkg holds:
  - the state enum {IDLE, READ, WRITE, REFRESH};
  - the strobe-counter width function clog2(STROBE_CYCLES+1);
  - a one-hot decode function used for all three strobe vectors.
- One sub-module, qsram_refresh_timer, contains:
  - the interval counter, RefreshPending, and RefreshOverrun;
  - a RefreshTaken input that clears pending;
  - the row pointer with its wrap logic.

Test Plan:
- Reset then idle, defaults, REFRESH_INTERVAL=64: strobes 0 and ReqReady=1 one cycle after Reset falls. The first RowRefreshEdge[0] pulse lasts 2 cycles, starting 1 cycle after timer wrap at cycle 64.
- Write then read back: write 0xA5 to row 3 → ArrayWData=0xA5 and RowWriteEdge=16'h0008 for 2 cycles. Read row 3 with bench model returning 0xA5 → RspValid pulses exactly 3 cycles after accept, with RspRData=0xA5.
- Request during pending refresh: assert ReqValid for a read of row 5 in the wrap cycle → ReqReady=0. RowRefreshEdge pulse completes, one idle gap follows, then the read is accepted and RowReadEdge=16'h0020.
- Pointer wrap: run 16 refresh periods → RowRefreshEdge walks through 0x0001 to 0x8000, then returns to 0x0001.
- Overrun: REFRESH_INTERVAL=6, STROBE_CYCLES=2, host holding ReqValid continuously → RefreshOverrun never sets. Then force pending by holding Reset low and stalling via a back-to-back timer wrap (bench parameter REFRESH_INTERVAL=2 with check disabled) → RefreshOverrun=1 and sticky until Reset.
- Reset mid-read: assert Reset in the second strobe cycle of a read → RowReadEdge=0 next cycle, no RspValid, and ReqReady=1 one cycle after Reset deasserts.

Source files
------------

// File: rtl/qsram_ctrl_pkg.sv
// Shared types and helpers for the QSRAM access controller.
// Row decode is sized for arrays of up to 2**MAX_ADDR_WIDTH rows.
package qsram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

  localparam int MAX_ADDR_WIDTH = 8;
  localparam int MAX_ROWS       = 2 ** MAX_ADDR_WIDTH;

  function automatic int strobe_cnt_width(input int strobe_cycles);
    return $clog2(strobe_cycles + 1);
  endfunction

  function automatic logic [MAX_ROWS-1:0] onehot_decode(input logic [MAX_ADDR_WIDTH-1:0] idx);
    logic [MAX_ROWS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Free-running refresh interval timer, pending/overrun flags and the
// refresh row pointer that walks every row of the array.
module qsram_refresh_timer #(
  parameter int ADDR_WIDTH       = 4,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_refresh_taken,
  input  logic                  i_refresh_done,
  output logic                  o_refresh_pending,
  output logic                  o_refresh_overrun,
  output logic [ADDR_WIDTH-1:0] o_row_ptr
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0]         r_timer;
  logic                  r_pending;
  logic                  r_overrun;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  w_wrap;

  assign w_wrap = (r_timer == T_LAST);

  // A wrap in the same cycle the FSM takes the refresh leaves a new one pending.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      if (w_wrap)
        r_pending <= 1'b1;
      else if (i_refresh_taken)
        r_pending <= 1'b0;
      if (w_wrap && r_pending)
        r_overrun <= 1'b1;
      if (i_refresh_done)
        r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_refresh_pending = r_pending;
  assign o_refresh_overrun = r_overrun;
  assign o_row_ptr         = r_ptr;

endmodule

// File: rtl/qsram_access_controller.sv
// Arbitrates host reads/writes against periodic row refresh for a QSRAM
// array; all row strobes are registered and mutually exclusive.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no strobe; takes a pending refresh first, else a host request
// ST_READ    | RowReadEdge[addr] high; ArrayRData captured on last cycle
// ST_WRITE   | RowWriteEdge[addr] high with ArrayWData held stable
// ST_REFRESH | RowRefreshEdge[ptr] high; pointer advances on exit
module qsram_access_controller
  import qsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int REFRESH_INTERVAL = 64,
  parameter int STROBE_CYCLES    = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [ADDR_WIDTH-1:0]    ReqAddr,
  input  logic [DATA_WIDTH-1:0]    ReqWData,
  output logic                     RspValid,
  output logic [DATA_WIDTH-1:0]    RspRData,
  output logic [2**ADDR_WIDTH-1:0] RowReadEdge,
  output logic [2**ADDR_WIDTH-1:0] RowWriteEdge,
  output logic [2**ADDR_WIDTH-1:0] RowRefreshEdge,
  output logic [DATA_WIDTH-1:0]    ArrayWData,
  input  logic [DATA_WIDTH-1:0]    ArrayRData,
  output logic                     RefreshOverrun
);

  localparam int ROWS = 2 ** ADDR_WIDTH;
  localparam int CW   = strobe_cnt_width(STROBE_CYCLES);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

  state_e                r_state, w_state_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next, w_ptr;
  logic [ROWS-1:0]       r_read_edge, r_write_edge, r_refresh_edge;
  logic [ROWS-1:0]       w_read_next, w_write_next, w_refresh_next;
  logic [ROWS-1:0]       w_addr_dec, w_ptr_dec;
  logic [DATA_WIDTH-1:0] r_rdata, r_wdata;
  logic                  r_rsp_valid, w_rsp_next;
  logic                  w_accept, w_last, w_pending, w_refresh_taken, w_refresh_done;

  qsram_refresh_timer #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .i_clock           (Clock),
    .i_reset           (Reset),
    .i_refresh_taken   (w_refresh_taken),
    .i_refresh_done    (w_refresh_done),
    .o_refresh_pending (w_pending),
    .o_refresh_overrun (RefreshOverrun),
    .o_row_ptr         (w_ptr)
  );

  assign ReqReady        = (r_state == ST_IDLE) && !w_pending && !Reset;
  assign w_accept        = ReqValid && ReqReady;
  assign w_last          = (r_cnt == '0);
  assign w_refresh_taken = (r_state == ST_IDLE) && w_pending;
  assign w_refresh_done  = (r_state == ST_REFRESH) && w_last;
  assign w_addr_next     = w_accept ? ReqAddr : r_addr;
  assign w_addr_dec      = ROWS'(onehot_decode(MAX_ADDR_WIDTH'(w_addr_next)));
  assign w_ptr_dec       = ROWS'(onehot_decode(MAX_ADDR_WIDTH'(w_ptr)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_read_edge    <= '0;
      r_write_edge   <= '0;
      r_refresh_edge <= '0;
      r_rsp_valid    <= 1'b0;
      r_rdata        <= '0;
      r_wdata        <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_addr         <= w_addr_next;
      r_read_edge    <= w_read_next;
      r_write_edge   <= w_write_next;
      r_refresh_edge <= w_refresh_next;
      r_rsp_valid    <= w_rsp_next;
      if (w_rsp_next)
        r_rdata <= ArrayRData;
      if (w_accept && ReqWrite)
        r_wdata <= ReqWData;
    end
  end

  // Strobe states count down from STROBE_LAST and always fall back to idle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_state_next = ST_REFRESH;
          w_cnt_next   = STROBE_LAST;
        end else if (w_accept) begin
          w_state_next = ReqWrite ? ST_WRITE : ST_READ;
          w_cnt_next   = STROBE_LAST;
        end
      end
      default: begin
        if (w_last)
          w_state_next = ST_IDLE;
        else
          w_cnt_next = r_cnt - 1'b1;
      end
    endcase
  end

  always_comb begin
    w_read_next    = '0;
    w_write_next   = '0;
    w_refresh_next = '0;
    w_rsp_next     = (r_state == ST_READ) && w_last;
    case (w_state_next)
      ST_READ:    w_read_next    = w_addr_dec;
      ST_WRITE:   w_write_next   = w_addr_dec;
      ST_REFRESH: w_refresh_next = w_ptr_dec;
      default:    ;
    endcase
  end

  assign RowReadEdge    = r_read_edge;
  assign RowWriteEdge   = r_write_edge;
  assign RowRefreshEdge = r_refresh_edge;
  assign RspValid       = r_rsp_valid;
  assign RspRData       = r_rdata;
  assign ArrayWData     = r_wdata;

endmodule

// File: tb/tb_qsram_access_controller.sv
// Directed bench for qsram_access_controller: a scoreboard queue holds expected
// read responses and a negedge monitor checks every RspValid pulse.
module tb_qsram_access_controller;

  logic        Clock;
  logic        Reset;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata, rsp_rdata, array_wdata, array_rdata;
  logic        rsp_valid, overrun;
  logic [15:0] row_read, row_write, row_refresh;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_overrun;
  logic [3:0]  b_req_addr;
  logic [7:0]  b_req_wdata, b_rsp_rdata, b_array_wdata, b_array_rdata;
  logic [15:0] b_row_read, b_row_write, b_row_refresh;

  logic        c_req_valid, c_req_ready, c_req_write, c_rsp_valid, c_overrun;
  logic [3:0]  c_req_addr;
  logic [7:0]  c_req_wdata, c_rsp_rdata, c_array_wdata, c_array_rdata;
  logic [15:0] c_row_read, c_row_write, c_row_refresh;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem[16];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  qsram_access_controller u_dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(rsp_valid), .RspRData(rsp_rdata), .RowReadEdge(row_read),
    .RowWriteEdge(row_write), .RowRefreshEdge(row_refresh),
    .ArrayWData(array_wdata), .ArrayRData(array_rdata), .RefreshOverrun(overrun)
  );

  qsram_access_controller #(.REFRESH_INTERVAL(6)) u_dut_busy (
    .Clock(Clock), .Reset(Reset), .ReqValid(b_req_valid), .ReqReady(b_req_ready),
    .ReqWrite(b_req_write), .ReqAddr(b_req_addr), .ReqWData(b_req_wdata),
    .RspValid(b_rsp_valid), .RspRData(b_rsp_rdata), .RowReadEdge(b_row_read),
    .RowWriteEdge(b_row_write), .RowRefreshEdge(b_row_refresh),
    .ArrayWData(b_array_wdata), .ArrayRData(b_array_rdata), .RefreshOverrun(b_overrun)
  );

  qsram_access_controller #(.REFRESH_INTERVAL(2)) u_dut_fast (
    .Clock(Clock), .Reset(Reset), .ReqValid(c_req_valid), .ReqReady(c_req_ready),
    .ReqWrite(c_req_write), .ReqAddr(c_req_addr), .ReqWData(c_req_wdata),
    .RspValid(c_rsp_valid), .RspRData(c_rsp_rdata), .RowReadEdge(c_row_read),
    .RowWriteEdge(c_row_write), .RowRefreshEdge(c_row_refresh),
    .ArrayWData(c_array_wdata), .ArrayRData(c_array_rdata), .RefreshOverrun(c_overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycle 0 is the first cycle with Reset low.
  always @(posedge Clock) begin
    if (Reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

  always @(posedge Clock) begin
    for (int i = 0; i < 16; i++)
      if (row_write[i]) mem[i] <= array_wdata;
  end

  always_comb begin
    array_rdata = '0;
    for (int i = 0; i < 16; i++)
      if (row_read[i]) array_rdata = mem[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    chk("strobe_onehot", 32'($onehot0({row_read, row_write, row_refresh})), 32'd1);
    chk("busy_strobe_onehot", 32'($onehot0({b_row_read, b_row_write, b_row_refresh})), 32'd1);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got RspValid=1 data 0x%0h expected no response (cycle %0d)",
                 rsp_rdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_rdata), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic go_cyc(input int n);
    do tick(); while (cyc < n);
  endtask

  task automatic at_neg(input int n);
    do @(negedge Clock); while (cyc < n);
  endtask

  task automatic issue(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit push_rsp, output int acc_cyc);
    int   n;
    exp_t e;
    n         = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge Clock);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge Clock);
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ReqReady=0 for 20 cycles expected acceptance (cycle %0d)", cyc);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      if (!wr && push_rsp) begin
        e.data = exp_rd;
        e.cyc  = cyc + 3;
        sb.push_back(e);
      end
    end
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    Reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 4'd2; b_req_wdata = 8'h00; b_array_rdata = 8'h00;
    c_req_valid = 0; c_req_write = 0; c_req_addr = 4'd0; c_req_wdata = 8'h00; c_array_rdata = 8'h00;

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_strobes", 32'(row_read | row_write | row_refresh), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_rdata", 32'(rsp_rdata), 0);
    chk("reset_wdata", 32'(array_wdata), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    at_neg(0);
    chk("idle_ready", 32'(req_ready), 1);
    chk("idle_strobes", 32'(row_read | row_write | row_refresh), 0);

    at_neg(5);
    chk("fast_overrun_clear", 32'(c_overrun), 0);
    at_neg(6);
    chk("fast_overrun_set", 32'(c_overrun), 1);

    at_neg(64);
    chk("wrap_no_strobe_yet", 32'(row_refresh), 0);
    chk("wrap_ready_stalled", 32'(req_ready), 0);
    at_neg(65);
    chk("refresh0_first", 32'(row_refresh), 32'h0001);
    at_neg(66);
    chk("refresh0_second", 32'(row_refresh), 32'h0001);
    at_neg(67);
    chk("refresh0_done", 32'(row_refresh), 0);
    chk("refresh0_ready", 32'(req_ready), 1);

    go_cyc(70);
    issue(1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, acc);
    chk("write_accept_cycle", 32'(acc), 70);
    at_neg(71);
    chk("write_edge_1", 32'(row_write), 32'h0008);
    chk("write_data", 32'(array_wdata), 32'hA5);
    at_neg(72);
    chk("write_edge_2", 32'(row_write), 32'h0008);
    at_neg(73);
    chk("write_edge_end", 32'(row_write), 0);
    chk("write_data_held", 32'(array_wdata), 32'hA5);

    go_cyc(74);
    issue(1'b0, 4'd3, 8'h00, 8'hA5, 1'b1, acc);
    chk("read_accept_cycle", 32'(acc), 74);
    at_neg(75);
    chk("read_edge_1", 32'(row_read), 32'h0008);
    at_neg(76);
    chk("read_edge_2", 32'(row_read), 32'h0008);
    at_neg(77);
    chk("read_edge_end", 32'(row_read), 0);
    at_neg(78);
    chk("rsp_single_pulse", 32'(rsp_valid), 0);

    go_cyc(128);
    fork
      issue(1'b0, 4'd5, 8'h00, 8'h15, 1'b1, acc);
      begin
        at_neg(128);
        chk("pending_stall", 32'(req_ready), 0);
        at_neg(129);
        chk("refresh1_first", 32'(row_refresh), 32'h0002);
        at_neg(130);
        chk("refresh1_second", 32'(row_refresh), 32'h0002);
        at_neg(131);
        chk("refresh1_gap", 32'(row_refresh | row_read), 0);
      end
    join
    chk("stalled_accept_cycle", 32'(acc), 131);
    at_neg(132);
    chk("stalled_read_edge_1", 32'(row_read), 32'h0020);
    at_neg(133);
    chk("stalled_read_edge_2", 32'(row_read), 32'h0020);

    at_neg(140);
    chk("rdata_hold", 32'(rsp_rdata), 32'h15);

    for (int k = 2; k <= 16; k++) begin
      at_neg(64 * (k + 1) + 1);
      chk("ptr_walk_first", 32'(row_refresh), 32'(1) << (k % 16));
      at_neg(64 * (k + 1) + 2);
      chk("ptr_walk_second", 32'(row_refresh), 32'(1) << (k % 16));
    end

    at_neg(1090);
    chk("busy_no_overrun", 32'(b_overrun), 0);
    chk("fast_overrun_sticky", 32'(c_overrun), 1);
    chk("main_no_overrun", 32'(overrun), 0);

    go_cyc(1100);
    issue(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, acc);
    chk("abort_accept_cycle", 32'(acc), 1100);
    at_neg(1101);
    chk("abort_edge_1", 32'(row_read), 32'h0008);
    go_cyc(1102);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_edge_2", 32'(row_read), 32'h0008);
    chk("abort_ready_low", 32'(req_ready), 0);
    tick();
    @(negedge Clock);
    chk("abort_edge_dropped", 32'(row_read | row_write | row_refresh), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rdata_cleared", 32'(rsp_rdata), 0);
    chk("abort_wdata_cleared", 32'(array_wdata), 0);
    chk("abort_fast_overrun_cleared", 32'(c_overrun), 0);
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_reset_ready", 32'(req_ready), 1);
    chk("post_reset_strobes", 32'(row_read | row_write | row_refresh), 0);
    repeat (6) @(negedge Clock);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
